// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared types and constants for the VGA raster timing generator.
//   - cnt_t          : 12-bit raster counter / coordinate type
//   - vga_timing_t   : one complete timing set (porches, sync, active, polarity)
//   - VGA_640x480_60 : default 640x480 @ 60 Hz mode
//   - SVGA_800x600_60: 800x600 @ 60 Hz mode
//   - total()        : length of one axis (active + porches + sync)
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W         = 12;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hsync_pol;
        bit vsync_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    localparam vga_timing_t SVGA_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster output bundle of the timing generator.
//   master: driven by vga_timing_gen; slave: pixel source / VGA pins.
//   hsync, vsync        : sync pulses (polarity set by the generator)
//   de                  : active-area data enable
//   x, y                : active pixel coordinates
//   line_start          : one-cycle pulse at h=0 of every line
//   frame_start         : one-cycle pulse at h=0, v=0
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic hsync;
    logic vsync;
    logic de;
    cnt_t x;
    cnt_t y;
    logic line_start;
    logic frame_start;

    modport master (output hsync, vsync, de, x, y, line_start, frame_start);
    modport slave  (input  hsync, vsync, de, x, y, line_start, frame_start);

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   Wrapping counter 0..TOTAL-1 for one raster axis.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   inc        : advance by one this cycle
//   cnt        : current count
//   wrap       : high when this cycle's increment wraps TOTAL-1 back to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output cnt_t cnt,
    output logic wrap
);

    localparam cnt_t LAST = cnt_t'(TOTAL - 1);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = at_last ? '0 : cnt_q + cnt_t'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its peers, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = inc && at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing in the pixel clock domain. Horizontal and vertical
//   counters walk the raster; every output is registered from the counter
//   value before its increment, so pins lag the counters by one cycle.
//   clk   : pixel clock (buffered MMCM output)
//   rst_n : asynchronous active-low reset
//   en    : advance enable; low freezes counters and outputs, pulses forced 0
//   vga   : raster outputs (hsync, vsync, de, x, y, line_start, frame_start)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_640x480_60.h_active,
    parameter int H_FP      = VGA_640x480_60.h_fp,
    parameter int H_SYNC    = VGA_640x480_60.h_sync,
    parameter int H_BP      = VGA_640x480_60.h_bp,
    parameter int V_ACTIVE  = VGA_640x480_60.v_active,
    parameter int V_FP      = VGA_640x480_60.v_fp,
    parameter int V_SYNC    = VGA_640x480_60.v_sync,
    parameter int V_BP      = VGA_640x480_60.v_bp,
    parameter bit HSYNC_POL = VGA_640x480_60.hsync_pol,
    parameter bit VSYNC_POL = VGA_640x480_60.vsync_pol
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
        $error("vga_timing_gen: every timing parameter must be >= 1");
    end
    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end

    // Region boundaries. A back porch of at least one keeps the sync end
    // below the axis total, so every boundary fits the counter width.
    localparam cnt_t H_ACT_END    = cnt_t'(H_ACTIVE);
    localparam cnt_t H_SYNC_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_ACT_END    = cnt_t'(V_ACTIVE);
    localparam cnt_t V_SYNC_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_wrap;
    logic v_wrap_unused;   // frame_start is decoded from (0,0) instead

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (en),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (en && h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap_unused)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    cnt_t x_q, x_d;
    cnt_t y_q, y_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    logic in_active;
    logic in_hsync;
    logic in_vsync;

    assign in_active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign in_hsync  = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    assign in_vsync  = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

    always_comb begin
        // NOTE: every output gets its hold value first, so no path through
        // this block leaves a signal unassigned and no latch is inferred.
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en) begin
            hsync_d       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = in_vsync ? VSYNC_POL : ~VSYNC_POL;
            de_d          = in_active;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            // x/y keep the last active coordinate through blanking.
            if (in_active) begin
                x_d = h_cnt;
                y_d = v_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two generators: the default 640x480 mode and a tiny 12x7 raster with
//   active-high syncs. A raster model indexed by linear pixel position
//   predicts every output; literal expectations pin the model and the DUT.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam vga_timing_t T0 = VGA_640x480_60;
    localparam vga_timing_t T1 = '{
        h_active: 8, h_fp: 1, h_sync: 2, h_bp: 1,
        v_active: 4, v_fp: 1, v_sync: 1, v_bp: 1,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };
    localparam int FRAME0 = total(T0.h_active, T0.h_fp, T0.h_sync, T0.h_bp) *
                            total(T0.v_active, T0.v_fp, T0.v_sync, T0.v_bp);
    localparam int FRAME1 = total(T1.h_active, T1.h_fp, T1.h_sync, T1.h_bp) *
                            total(T1.v_active, T1.v_fp, T1.v_sync, T1.v_bp);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        cnt_t x;
        cnt_t y;
        logic line_start;
        logic frame_start;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en0   = 1'b0;
    logic en1   = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if vga0 ();
    vga_timing_gen_if vga1 ();

    vga_timing_gen dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en0),
        .vga   (vga0.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (T1.h_active), .H_FP (T1.h_fp), .H_SYNC (T1.h_sync), .H_BP (T1.h_bp),
        .V_ACTIVE (T1.v_active), .V_FP (T1.v_fp), .V_SYNC (T1.v_sync), .V_BP (T1.v_bp),
        .HSYNC_POL (T1.hsync_pol), .VSYNC_POL (T1.vsync_pol)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en1),
        .vga   (vga1.master)
    );

    obs_t act0, act1;
    assign act0 = {vga0.hsync, vga0.vsync, vga0.de, vga0.x, vga0.y, vga0.line_start, vga0.frame_start};
    assign act1 = {vga1.hsync, vga1.vsync, vga1.de, vga1.x, vga1.y, vga1.line_start, vga1.frame_start};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- raster model ----------------
    function automatic obs_t reset_obs(input vga_timing_t t);
        obs_t o = '0;
        o.hsync = ~t.hsync_pol;
        o.vsync = ~t.vsync_pol;
        return o;
    endfunction

    // Outputs presented after an enabled edge at linear raster position p.
    function automatic obs_t next_obs(input vga_timing_t t, input int p, input obs_t prev);
        int   ht    = total(t.h_active, t.h_fp, t.h_sync, t.h_bp);
        int   h     = p % ht;
        int   v     = p / ht;
        int   hs0   = t.h_active + t.h_fp;
        int   vs0   = t.v_active + t.v_fp;
        obs_t o     = prev;
        o.de          = (h < t.h_active) && (v < t.v_active);
        if (o.de) begin
            o.x = cnt_t'(h);
            o.y = cnt_t'(v);
        end
        o.hsync       = (h >= hs0 && h < hs0 + t.h_sync) ? t.hsync_pol : ~t.hsync_pol;
        o.vsync       = (v >= vs0 && v < vs0 + t.v_sync) ? t.vsync_pol : ~t.vsync_pol;
        o.line_start  = (h == 0);
        o.frame_start = (p == 0);
        return o;
    endfunction

    function automatic obs_t frozen(input obs_t prev);
        obs_t o = prev;
        o.line_start  = 1'b0;
        o.frame_start = 1'b0;
        return o;
    endfunction

    obs_t exp0, exp1;
    int   pos0, pos1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos0 <= 0;
            pos1 <= 0;
            exp0 <= reset_obs(T0);
            exp1 <= reset_obs(T1);
        end else begin
            if (en0) begin
                exp0 <= next_obs(T0, pos0, exp0);
                pos0 <= (pos0 + 1) % FRAME0;
            end else begin
                exp0 <= frozen(exp0);
            end
            if (en1) begin
                exp1 <= next_obs(T1, pos1, exp1);
                pos1 <= (pos1 + 1) % FRAME1;
            end else begin
                exp1 <= frozen(exp1);
            end
        end
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model dut0", 32'(act0), 32'(exp0));
            check("model dut1", 32'(act1), 32'(exp1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit e0, input bit e1);
        en0 = e0;
        en1 = e1;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit rnd_en();
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    localparam obs_t RST0   = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, x: '0, y: '0, line_start: 1'b0, frame_start: 1'b0};
    localparam obs_t RST1   = '{hsync: 1'b0, vsync: 1'b0, de: 1'b0, x: '0, y: '0, line_start: 1'b0, frame_start: 1'b0};
    localparam obs_t FIRST0 = '{hsync: 1'b1, vsync: 1'b1, de: 1'b1, x: '0, y: '0, line_start: 1'b1, frame_start: 1'b1};
    localparam obs_t FIRST1 = '{hsync: 1'b0, vsync: 1'b0, de: 1'b1, x: '0, y: '0, line_start: 1'b1, frame_start: 1'b1};

    initial begin
        int de_line0, hs_first, hs_last, hs_cnt;
        int vs1_first, vs1_cnt, hs1_first, hs1_cnt, de_line3;
        int ls_q[$];
        int fs1_q[$];
        bit found;
        de_line0 = 0; hs_first = -1; hs_last = -1; hs_cnt = 0;
        vs1_first = -1; vs1_cnt = 0; hs1_first = -1; hs1_cnt = 0; de_line3 = 0;

        // Reset held with en high: outputs must sit at their reset values.
        #1 rst_n = 1'b0;
        en0 = 1'b1;
        en1 = 1'b1;
        cmp_on = 1'b1;
        repeat (3) @(negedge clk);
        check("reset dut0", 32'(act0), 32'(RST0));
        check("reset dut1", 32'(act1), 32'(RST1));
        rst_n = 1'b1;

        // Three uninterrupted lines of dut0; two frames of dut1.
        for (int k = 0; k < 2400; k++) begin
            step(1'b1, 1'b1);
            if (k == 0) begin
                check("first edge dut0", 32'(act0), 32'(FIRST0));
                check("first edge dut1", 32'(act1), 32'(FIRST1));
            end
            if (k < 800 && vga0.de) de_line0++;
            if (k < 800 && !vga0.hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_last = k;
                hs_cnt++;
            end
            if (vga0.line_start) ls_q.push_back(k);
            if (k == 639) check("last pixel line0", 32'({vga0.de, vga0.x, vga0.y}), 32'({1'b1, 12'd639, 12'd0}));
            if (k == 640) check("x held in blank", 32'({vga0.de, vga0.x}), 32'({1'b0, 12'd639}));
            if (k < 168 && vga1.frame_start) fs1_q.push_back(k);
            if (k < 84 && vga1.vsync) begin
                if (vs1_first < 0) vs1_first = k;
                vs1_cnt++;
            end
            if (k < 12 && vga1.hsync) begin
                if (hs1_first < 0) hs1_first = k;
                hs1_cnt++;
            end
            if (k == 43) check("last pixel dut1", 32'({vga1.de, vga1.x, vga1.y}), 32'({1'b1, 12'd7, 12'd3}));
        end
        check("de cycles line0", 32'(de_line0), 32'd640);
        check("hsync first", 32'(hs_first), 32'd656);
        check("hsync last", 32'(hs_last), 32'd751);
        check("hsync width", 32'(hs_cnt), 32'd96);
        check("line_start count", 32'(ls_q.size()), 32'd3);
        if (ls_q.size() == 3) begin
            check("line_start period a", 32'(ls_q[1] - ls_q[0]), 32'd800);
            check("line_start period b", 32'(ls_q[2] - ls_q[1]), 32'd800);
        end
        check("dut1 frame_start count", 32'(fs1_q.size()), 32'd2);
        if (fs1_q.size() == 2) check("dut1 frame period", 32'(fs1_q[1] - fs1_q[0]), 32'd84);
        check("dut1 vsync line5 first", 32'(vs1_first), 32'd60);
        check("dut1 vsync width", 32'(vs1_cnt), 32'd12);
        check("dut1 hsync first", 32'(hs1_first), 32'd9);
        check("dut1 hsync width", 32'(hs1_cnt), 32'd2);

        // Line 3 of dut0 with a 5-cycle stall while x=100 is on the pins.
        for (int k = 2400; k <= 2500; k++) begin
            step(1'b1, rnd_en());
            if (vga0.de) de_line3++;
        end
        check("pre-stall x", 32'({vga0.de, vga0.x}), 32'({1'b1, 12'd100}));
        for (int k = 0; k < 5; k++) begin
            step(1'b0, rnd_en());
            check("stall frozen", 32'({vga0.de, vga0.x, vga0.line_start, vga0.frame_start}),
                  32'({1'b1, 12'd100, 1'b0, 1'b0}));
        end
        for (int k = 2501; k < 3200; k++) begin
            step(1'b1, rnd_en());
            if (vga0.de) de_line3++;
            if (k == 2501) check("resume x", 32'(vga0.x), 32'd101);
        end
        check("de cycles line3", 32'(de_line3), 32'd640);

        // Random enable until dut0 shows (300, 20), then reset mid-frame.
        found = 1'b0;
        for (int i = 0; i < 40000 && !found; i++) begin
            step(rnd_en(), rnd_en());
            if (vga0.de && vga0.x == 12'd300 && vga0.y == 12'd20) found = 1'b1;
        end
        check("reached x300 y20", 32'(found), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset dut0", 32'(act0), 32'(RST0));
        check("async reset dut1", 32'(act1), 32'(RST1));
        @(negedge clk);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        check("restart dut0", 32'(act0), 32'(FIRST0));
        check("restart dut1", 32'(act1), 32'(FIRST1));

        // Random enable with occasional short resets.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 399) == 0) pulse_reset();
            step(rnd_en(), rnd_en());
        end

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
